// File: rtl/prog_lut.sv
// Programmable lookup table: streamed load port fills the table, NRD independent
// read channels return registered data one cycle after acceptance.
module prog_lut #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NRD    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     ld_valid,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    output logic [ADDR_W:0]          ld_count,
    input  logic [NRD-1:0]           rd_req,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic                     rd_ready,
    output logic [NRD-1:0]           rd_valid,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD-1:0]           rd_err,
    output logic                     busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               loaded_q, loaded_d;
    logic               wr_en;

    logic [DATA_W-1:0]  mem [DEPTH];

    // The word counter doubles as the write pointer; it only reaches DEPTH on exit from LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

    // Next-state, counter and write-enable decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        wr_en    = 1'b0;
        case (state_q)
            ST_EMPTY, ST_READY: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    cnt_d = '0;
                end else if (ld_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (ld_last || (cnt_q == CNT_W'(DEPTH - 1))) begin
                        state_d  = ST_READY;
                        loaded_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        busy     = 1'b0;
        ld_ready = 1'b0;
        rd_ready = 1'b1;
        if (state_q == ST_LOAD) begin
            busy     = 1'b1;
            ld_ready = 1'b1;
            rd_ready = 1'b0;
        end
    end

    assign ld_count = cnt_q;

    // Table storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt_q[ADDR_W-1:0]] <= ld_data;
        end
    end

    // Per-channel registered read; data holds when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
            rd_err   <= '0;
            rd_data  <= '0;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                rd_valid[k] <= rd_req[k] & rd_ready;
                rd_err[k]   <= rd_req[k] & rd_ready & ~loaded_q;
                if (rd_req[k] && rd_ready) begin
                    rd_data[k*DATA_W +: DATA_W] <= loaded_q ? mem[rd_addr[k*ADDR_W +: ADDR_W]]
                                                            : DATA_W'(0);
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_lut.sv
// Bench for prog_lut: directed scenarios then random traffic, all checked against
// a table-level reference model.
module tb_prog_lut;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [8:0]  ld_count;
    logic [1:0]  rd_req;
    logic [15:0] rd_addr;
    logic        rd_ready;
    logic [1:0]  rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_err;
    logic        busy;

    prog_lut #(.ADDR_W(8), .DATA_W(16), .NRD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_count(ld_count),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: table contents plus "loading" / "ever fully loaded" view.
    logic [15:0] m_mem [256];
    bit          m_known [256];
    bit          m_loading;
    bit          m_loaded;
    int          m_cnt;
    bit          e_valid [2];
    bit          e_err [2];
    bit          e_ok [2];
    logic [15:0] e_data [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_loaded  = 1'b0;
        m_cnt     = 0;
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = 1'b0;
            e_err[k]   = 1'b0;
            e_ok[k]    = 1'b1;
            e_data[k]  = 16'h0;
        end
    endtask

    task automatic check_all();
        check("busy", busy, m_loading);
        check("ld_ready", ld_ready, m_loading);
        check("rd_ready", rd_ready, !m_loading);
        check("ld_count", ld_count, m_cnt);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rd_valid%0d", k), rd_valid[k], e_valid[k]);
            check($sformatf("rd_err%0d", k), rd_err[k], e_err[k]);
            if (e_ok[k]) check($sformatf("rd_data%0d", k), rd_data[k*16 +: 16], e_data[k]);
        end
    endtask

    // Predict the effect of the current inputs, clock once, then compare.
    task automatic cycle();
        bit accept_rd;
        int a;
        accept_rd = !m_loading;
        for (int k = 0; k < 2; k++) begin
            a = int'(rd_addr[k*8 +: 8]);
            if (rd_req[k] && accept_rd) begin
                e_valid[k] = 1'b1;
                e_err[k]   = !m_loaded;
                if (m_loaded) begin
                    e_data[k] = m_mem[a];
                    e_ok[k]   = m_known[a];
                end else begin
                    e_data[k] = 16'h0;
                    e_ok[k]   = 1'b1;
                end
            end else begin
                e_valid[k] = 1'b0;
                e_err[k]   = 1'b0;
            end
        end
        if (load_start) begin
            m_loading = 1'b1;
            m_cnt     = 0;
        end else if (m_loading && ld_valid) begin
            m_mem[m_cnt]   = ld_data;
            m_known[m_cnt] = 1'b1;
            m_cnt++;
            if (ld_last || m_cnt == 256) begin
                m_loading = 1'b0;
                m_loaded  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    logic [15:0] words [4];

    initial begin
        words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC; words[3] = 16'hDDDD;
        rst_n = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        rd_req = '0; rd_addr = '0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Read before any load
        rd_req = 2'b01; rd_addr = {8'd0, 8'd5};
        cycle();
        check("empty_read_data0", rd_data[15:0], 16'h0);
        check("empty_read_err", rd_err, 2'b01);
        rd_req = 2'b00;

        // Full 256-word load of addr*3
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ld_data = 16'(i * 3);
            cycle();
        end
        ld_valid = 1'b0;
        check("full_ld_count", ld_count, 9'd256);
        check("full_busy", busy, 1'b0);
        rd_req = 2'b11; rd_addr = {8'd255, 8'd10};
        cycle();
        check("full_read0", rd_data[15:0], 16'd30);
        check("full_read1", rd_data[31:16], 16'd765);
        check("full_read_err", rd_err, 2'b00);

        // Short gapped reload with reads held through LOAD
        rd_addr = {8'd4, 8'd2};
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b0;
            cycle();
            check("stall_valid", rd_valid, 2'b00);
            ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
            cycle();
            check("stall_valid", rd_valid, 2'b00);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        check("short_ld_count", ld_count, 9'd4);
        cycle();
        check("resume_valid", rd_valid, 2'b11);
        check("short_read_new", rd_data[15:0], 16'hCCCC);
        check("short_read_old", rd_data[31:16], 16'd12);
        rd_req = 2'b00;

        // Read coinciding with load_start sees pre-load contents
        load_start = 1'b1;
        cycle();
        load_start = 1'b0; ld_valid = 1'b1; ld_data = 16'h1111; ld_last = 1'b1;
        cycle();
        ld_valid = 1'b0; ld_last = 1'b0;
        load_start = 1'b1; rd_req = 2'b01; rd_addr = 16'h0;
        cycle();
        check("race_old_data", rd_data[15:0], 16'h1111);
        load_start = 1'b0; rd_req = 2'b00;
        ld_valid = 1'b1; ld_data = 16'h2222; ld_last = 1'b1;
        cycle();
        ld_valid = 1'b0; ld_last = 1'b0; rd_req = 2'b01;
        cycle();
        check("race_new_data", rd_data[15:0], 16'h2222);
        rd_req = 2'b00;

        // Reset in the middle of a load
        load_start = 1'b1;
        cycle();
        load_start = 1'b0; ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_data = 16'(16'h0500 + i);
            cycle();
        end
        ld_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_ld_count", ld_count, 9'd0);
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        rd_req = 2'b01; rd_addr = {8'd0, 8'd1};
        cycle();
        check("post_rst_data", rd_data[15:0], 16'h0);
        check("post_rst_err", rd_err, 2'b01);
        rd_req = 2'b00;

        // Complete a full load so random reads are all predictable
        load_start = 1'b1;
        cycle();
        load_start = 1'b0; ld_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ld_data = 16'($urandom);
            cycle();
        end
        ld_valid = 1'b0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            load_start = ($urandom_range(0, 49) == 0);
            ld_valid   = ($urandom_range(0, 3) != 0);
            ld_data    = 16'($urandom);
            ld_last    = ($urandom_range(0, 99) == 0);
            rd_req     = 2'($urandom);
            rd_addr    = 16'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_lut.md
PROG_LUT -- requirements
Module: prog_lut

Interface
REQ-001 Parameter ADDR_W, default 8: address width; DEPTH = 2**ADDR_W entries.
REQ-002 Parameter DATA_W, default 16: entry width.
REQ-003 Parameter NRD, default 2: number of independent read channels.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 load_start  in  1  pulse to begin (re)loading the table from address 0.
REQ-007 ld_valid  in  1  load word present on ld_data.
REQ-008 ld_data  in  DATA_W  load word.
REQ-009 ld_last  in  1  marks final load word (qualified by ld_valid).
REQ-010 ld_ready  out  1  block accepts a load word this cycle.
REQ-011 ld_count  out  ADDR_W+1  words written in current or last load.
REQ-012 rd_req  in  NRD  per-channel read request.
REQ-013 rd_addr  in  NRD*ADDR_W  per-channel address, channel k at bits [k*ADDR_W +: ADDR_W].
REQ-014 rd_ready  out  1  reads accepted this cycle (common to all channels).
REQ-015 rd_valid  out  NRD  per-channel read-data valid.
REQ-016 rd_data  out  NRD*DATA_W  per-channel registered read data.
REQ-017 rd_err  out  NRD  per-channel: read returned while table never fully loaded.
REQ-018 busy  out  1  high while state is LOAD.

Function
REQ-019 FSM states EMPTY, LOAD, READY; reset state EMPTY.
REQ-020 EMPTY/READY --load_start--> LOAD; ld_count cleared to 0, write pointer to 0.
REQ-021 LOAD: ld_ready=1; on ld_valid&ld_ready, write ld_data at pointer, pointer+1, ld_count+1.
REQ-022 LOAD -> READY after the accepted word carrying ld_last, or after the DEPTH-th accepted word, whichever first; pointer never wraps.
REQ-023 ld_ready=0 in EMPTY and READY; ld_valid there is ignored, no write.
REQ-024 load_start during LOAD restarts: pointer and ld_count to 0, stay LOAD, no write that cycle.
REQ-025 Sticky flag loaded: set on LOAD->READY, cleared only by reset; an early ld_last still sets it (unwritten entries keep old contents).
REQ-026 rd_ready=1 in EMPTY and READY, 0 in LOAD (reads stall, no request is queued).
REQ-027 Read accept for channel k: rd_req[k]&rd_ready; rd_valid[k]=1 and rd_data[k]=table[rd_addr[k]] exactly one cycle later; else rd_valid[k]=0 and rd_data[k] holds.
REQ-028 Accepted read with loaded=0 returns rd_data[k]=0, rd_err[k]=1 (with rd_valid[k]); otherwise rd_err[k]=0.
REQ-029 Channels independent; identical addresses on several channels all return the same data.
REQ-030 load_start and rd_req same cycle in READY: read accepted, returns pre-load contents next cycle; first load write occurs no earlier than next cycle.
REQ-031 Table storage has no reset and is not cleared by load_start.

Reset
REQ-032 rst_n low asynchronously forces state EMPTY, loaded=0, pointer=0, ld_count=0, rd_valid=0, rd_data=0, rd_err=0; busy=0, ld_ready=0, rd_ready=1 follow.
REQ-033 Reset mid-LOAD abandons the load; already-written entries retained but loaded=0, so reads return 0 with rd_err until a full load completes.
REQ-034 First load_start honoured on the first rising edge with rst_n high.

Verification
REQ-035 Reset, then rd_req=01, rd_addr0=5 in EMPTY -> next cycle rd_valid=01, rd_data0=0, rd_err=01.
REQ-036 Defaults; load_start then 256 words value=addr*3 with ld_valid always high -> LOAD->READY after 256th word, ld_count=256; read ch0 addr 10, ch1 addr 255 -> 30 and 765 one cycle later, rd_err=00.
REQ-037 After full load, reload with 4 words 0xAAAA,0xBBBB,0xCCCC,0xDDDD, ld_last on 4th, ld_valid gapped -> ld_count=4; addr 2 reads 0xCCCC, addr 4 reads 12 (old).
REQ-038 rd_req=11 held during LOAD -> rd_ready=0, rd_valid=00 throughout; first rd_valid one cycle after entering READY.
REQ-039 load_start with rd_req ch0 addr 0 in READY (addr0=0x1111), write 0x2222 next -> rd_data0=0x1111; later read returns 0x2222.
REQ-040 rst_n low after 3 of 8 load words -> busy=0, ld_count=0 immediately; subsequent read returns 0 with rd_err=1.
